hilo_div_ctrl: RTL and testbench

EX-stage controller sitting directly upstream of the iterative divider, owning the HI/LO architectural registers. Accepts DIV/DIVU from the EX stage, drives the divider's start/annul/signed/operand handshake, stalls the pipeline while the divide runs, and commits the 64-bit result into HI/LO. Also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

---
 rtl/hilo_div_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EX-stage controller in front of the iterative divider.
// Owns the HI/LO architectural registers. Issues DIV/DIVU to the divider,
// stalls the pipeline while it runs, and commits {remainder, quotient}
// into HI/LO. Also services MTHI/MTLO and supplies HI/LO for MFHI/MFLO.
//
// Optional feature macro: HILO_FWD_EN
//   defined   -> hi_o/lo_o forward the value being written this cycle
//   undefined -> hi_o/lo_o show the registered values only
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Unqualified (pre-reset-gating) divider handshake and stall.
  logic        start_c;
  logic        annul_c;
  logic        signed_c;
  logic [31:0] op1_c;
  logic [31:0] op2_c;
  logic        stall_c;
  logic        commit_c;

  // Next-state logic, operand latching and the divider handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb infers a latch.
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    signed_d = signed_q;
    start_c  = 1'b0;
    annul_c  = 1'b0;
    signed_c = 1'b0;
    op1_c    = '0;
    op2_c    = '0;
    stall_c  = 1'b0;
    commit_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          // Operands go straight through on the issue cycle and are
          // captured so they stay stable for the whole divide.
          start_c  = 1'b1;
          stall_c  = 1'b1;
          signed_c = div_signed_i;
          op1_c    = opa_i;
          op2_c    = opb_i;
          opa_d    = opa_i;
          opb_d    = opb_i;
          signed_d = div_signed_i;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        // The divider re-reads operand signs at finalize, so keep driving
        // the latched copies rather than whatever EX now holds.
        signed_c = signed_q;
        op1_c    = opa_q;
        op2_c    = opb_q;
        if (flush_i) begin
          // Flush beats a same-cycle ready: annul, drop stall, no commit.
          annul_c = 1'b1;
          state_d = S_IDLE;
        end else begin
          start_c = 1'b1;
          stall_c = !div_ready_i;
          if (div_ready_i) begin
            commit_c = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Start low lets the divider return to free; a following DIV
        // held in EX waits one bubble here.
        stall_c = div_req_i;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // HI/LO write selection: MTHI/MTLO first, divide commit overrides them.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mthi_i) hi_d = wdata_i;
    if (mtlo_i) lo_d = wdata_i;
    if (commit_c) begin
      hi_d = div_result_i[63:32];
      lo_d = div_result_i[31:0];
    end
  end

  // State, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Output drive; everything is held at 0 while reset is asserted so a
  // request still present on the EX inputs cannot leak through.
  always_comb begin
    div_start_o  = 1'b0;
    div_annul_o  = 1'b0;
    div_signed_o = 1'b0;
    div_op1_o    = '0;
    div_op2_o    = '0;
    stall_o      = 1'b0;
    hi_o         = '0;
    lo_o         = '0;
    if (rst) begin
      div_start_o  = start_c;
      div_annul_o  = annul_c;
      div_signed_o = signed_c;
      div_op1_o    = op1_c;
      div_op2_o    = op2_c;
      stall_o      = stall_c;
`ifdef HILO_FWD_EN
      hi_o         = hi_d;
      lo_o         = lo_d;
`else
      hi_o         = hi_q;
      lo_o         = lo_q;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed testbench for hilo_div_ctrl. The bench plays the divider:
// it raises div_ready_i in cycle 35 after issue with a hand-computed
// {remainder, quotient}. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_hilo_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        flush_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] wdata_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp;
  int n_err;

  hilo_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .opa_i        (opa_i),
    .opb_i        (opb_i),
    .flush_i      (flush_i),
    .mthi_i       (mthi_i),
    .mtlo_i       (mtlo_i),
    .wdata_i      (wdata_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the drive point of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one divide from the issue cycle (caller is already at the drive
  // point of cycle 0) through the ready cycle 35. Returns at the drive
  // point of cycle 36 (DONE) with div_req_i dropped.
  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] quo,
                         input logic [31:0] rem, input logic mthi_at_ready);
    logic exp_stall;
    div_req_i    = 1'b1;
    div_signed_i = sgn;
    opa_i        = a;
    opb_i        = b;
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) begin
        tick();
        // EX-side operands wander; the divider must not see it.
        opa_i        = ~a;
        opb_i        = b ^ 32'h5555_5555;
        div_signed_i = ~sgn;
      end
      if (c == 35) begin
        div_ready_i  = 1'b1;
        div_result_i = {rem, quo};
        mthi_i       = mthi_at_ready;
        wdata_i      = 32'h0000_1234;
      end
      @(negedge clk);
      exp_stall = (c != 35);
      n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++;
        $display("FAIL div cyc%0d stall: got %b want %b", c, stall_o, exp_stall);
      end
      n_cmp++;
      if (div_start_o !== 1'b1) begin
        n_err++;
        $display("FAIL div cyc%0d start: got %b want 1", c, div_start_o);
      end
      n_cmp++;
      if (div_op1_o !== a || div_op2_o !== b || div_signed_o !== sgn) begin
        n_err++;
        $display("FAIL div cyc%0d operands: got %h/%h/%b want %h/%h/%b",
                 c, div_op1_o, div_op2_o, div_signed_o, a, b, sgn);
      end
    end
    tick();
    div_ready_i  = 1'b0;
    div_result_i = '0;
    mthi_i       = 1'b0;
    div_req_i    = 1'b0;
    div_signed_i = 1'b0;
    opa_i        = '0;
    opb_i        = '0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    div_req_i = 1'b1;
    opa_i     = 32'hDEAD_BEEF;
    opb_i     = 32'h0000_0003;
    mthi_i    = 1'b1;
    wdata_i   = 32'h7777_7777;
    @(negedge clk);
    n_cmp++;
    if ({div_start_o, div_annul_o, div_signed_o, stall_o} !== 4'b0) begin
      n_err++;
      $display("FAIL reset ctrl: got %b want 0000",
               {div_start_o, div_annul_o, div_signed_o, stall_o});
    end
    n_cmp++;
    if (div_op1_o !== 32'h0 || div_op2_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset ops: got %h/%h want 0/0", div_op1_o, div_op2_o);
    end
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset hilo: got %h/%h want 0/0", hi_o, lo_o);
    end
    tick();
    div_req_i = 1'b0;
    opa_i     = '0;
    opb_i     = '0;
    mthi_i    = 1'b0;
    wdata_i   = '0;
    rst       = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (div_start_o !== 1'b0 || stall_o !== 1'b0 || hi_o !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset idle: got start=%b stall=%b hi=%h want 0/0/0",
               div_start_o, stall_o, hi_o);
    end
  endtask

  // Shared DONE-cycle check: HI/LO committed, start low, no stall.
  task automatic test_done_cycle(input string name, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo);
    @(negedge clk);
    n_cmp++;
    if (hi_o !== exp_hi || lo_o !== exp_lo) begin
      n_err++;
      $display("FAIL %s hilo: got %h/%h want %h/%h", name, hi_o, lo_o, exp_hi, exp_lo);
    end
    n_cmp++;
    if (div_start_o !== 1'b0 || stall_o !== 1'b0 || div_annul_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_ctrl: got start=%b stall=%b annul=%b want 0/0/0",
               name, div_start_o, stall_o, div_annul_o);
    end
  endtask

  task automatic test_divu_basic();
    tick();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    test_done_cycle("divu_100_7", 32'd2, 32'd14);
  endtask

  task automatic test_div_signed();
    tick();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    test_done_cycle("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
  endtask

  task automatic test_div_zero();
    tick();
    run_div(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    test_done_cycle("div_5_0", 32'd0, 32'd0);
  endtask

  task automatic test_mt_fwd();
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    tick();
    mtlo_i  = 1'b1;
    wdata_i = 32'h0000_ABCD;
`ifdef HILO_FWD_EN
    exp_lo = 32'h0000_ABCD;
`else
    exp_lo = 32'h0000_0000;
`endif
    @(negedge clk);
    n_cmp++;
    if (lo_o !== exp_lo) begin
      n_err++;
      $display("FAIL mtlo same_cycle: got %h want %h", lo_o, exp_lo);
    end
    tick();
    mtlo_i  = 1'b0;
    mthi_i  = 1'b1;
    wdata_i = 32'h0000_5678;
`ifdef HILO_FWD_EN
    exp_hi = 32'h0000_5678;
`else
    exp_hi = 32'h0000_0000;
`endif
    @(negedge clk);
    n_cmp++;
    if (lo_o !== 32'h0000_ABCD) begin
      n_err++;
      $display("FAIL mtlo next_cycle: got %h want 0000abcd", lo_o);
    end
    n_cmp++;
    if (hi_o !== exp_hi) begin
      n_err++;
      $display("FAIL mthi same_cycle: got %h want %h", hi_o, exp_hi);
    end
    tick();
    mthi_i  = 1'b0;
    wdata_i = '0;
    @(negedge clk);
    n_cmp++;
    if (hi_o !== 32'h0000_5678 || lo_o !== 32'h0000_ABCD) begin
      n_err++;
      $display("FAIL mt hold: got %h/%h want 00005678/0000abcd", hi_o, lo_o);
    end
  endtask

  task automatic test_commit_vs_mthi();
    tick();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    test_done_cycle("commit_vs_mthi", 32'd2, 32'd14);
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks issue.
    tick();
    div_req_i = 1'b1;
    opa_i     = 32'd50;
    opb_i     = 32'd5;
    flush_i   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (div_start_o !== 1'b0 || stall_o !== 1'b0 || div_op1_o !== 32'h0) begin
      n_err++;
      $display("FAIL idle_flush issue: got start=%b stall=%b op1=%h want 0/0/0",
               div_start_o, stall_o, div_op1_o);
    end
    tick();
    div_req_i = 1'b0;
    flush_i   = 1'b0;
    mthi_i    = 1'b1;
    mtlo_i    = 1'b0;
    wdata_i   = 32'h0000_AAAA;
    @(negedge clk);
    n_cmp++;
    if (div_start_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_flush state: got start=%b want 0", div_start_o);
    end
    tick();
    mthi_i  = 1'b0;
    mtlo_i  = 1'b1;
    wdata_i = 32'h0000_BBBB;
    tick();
    mtlo_i  = 1'b0;
    wdata_i = '0;
    // Flush in cycle 10 of a divide.
    div_req_i    = 1'b1;
    div_signed_i = 1'b1;
    opa_i        = 32'd50;
    opb_i        = 32'd5;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      n_cmp++;
      if (stall_o !== 1'b1) begin
        n_err++;
        $display("FAIL flush_div cyc%0d stall: got %b want 1", c, stall_o);
      end
    end
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush cyc10: got annul=%b start=%b stall=%b want 1/0/0",
               div_annul_o, div_start_o, stall_o);
    end
    tick();
    flush_i      = 1'b0;
    div_req_i    = 1'b0;
    div_signed_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (div_annul_o !== 1'b0 || div_start_o !== 1'b0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush after: got annul=%b start=%b stall=%b want 0/0/0",
               div_annul_o, div_start_o, stall_o);
    end
    n_cmp++;
    if (hi_o !== 32'h0000_AAAA || lo_o !== 32'h0000_BBBB) begin
      n_err++;
      $display("FAIL flush hilo: got %h/%h want 0000aaaa/0000bbbb", hi_o, lo_o);
    end
    tick();
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    test_done_cycle("divu_9_3", 32'd0, 32'd3);
  endtask

  task automatic test_back_to_back();
    tick();
    run_div(1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 1'b0);
    // Cycle 36 (DONE): the next DIV is already in EX; flush here is ignored.
    div_req_i = 1'b1;
    opa_i     = 32'd9;
    opb_i     = 32'd4;
    flush_i   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall_o !== 1'b1 || div_start_o !== 1'b0 || div_annul_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b cyc36: got stall=%b start=%b annul=%b want 1/0/0",
               stall_o, div_start_o, div_annul_o);
    end
    n_cmp++;
    if (hi_o !== 32'd0 || lo_o !== 32'd4) begin
      n_err++;
      $display("FAIL b2b first hilo: got %h/%h want 0/4", hi_o, lo_o);
    end
    tick();
    flush_i = 1'b0;
    run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
    test_done_cycle("b2b_second", 32'd1, 32'd2);
  endtask

  task automatic test_reset_mid_divide();
    tick();
    div_req_i    = 1'b1;
    div_signed_i = 1'b0;
    opa_i        = 32'd100;
    opb_i        = 32'd7;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({div_start_o, div_annul_o, div_signed_o, stall_o} !== 4'b0 ||
        div_op1_o !== 32'h0 || div_op2_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid ctrl: got %b op %h/%h want 0000 op 0/0",
               {div_start_o, div_annul_o, div_signed_o, stall_o}, div_op1_o, div_op2_o);
    end
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid hilo: got %h/%h want 0/0", hi_o, lo_o);
    end
    tick();
    rst       = 1'b1;
    div_req_i = 1'b0;
    opa_i     = '0;
    opb_i     = '0;
    @(negedge clk);
    n_cmp++;
    if (div_start_o !== 1'b0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid idle: got start=%b stall=%b want 0/0", div_start_o, stall_o);
    end
    tick();
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    test_done_cycle("rst_recover", 32'd0, 32'd3);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    div_req_i    = 1'b0;
    div_signed_i = 1'b0;
    opa_i        = '0;
    opb_i        = '0;
    flush_i      = 1'b0;
    mthi_i       = 1'b0;
    mtlo_i       = 1'b0;
    wdata_i      = '0;
    div_result_i = '0;
    div_ready_i  = 1'b0;

    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_mt_fwd();
    test_commit_vs_mthi();
    test_flush();
    test_back_to_back();
    test_reset_mid_divide();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
